// File: rtl/vconv_multi.sv
// RGB -> YPbPr converter (Rec.601 / Rec.709, full or studio range) with a fixed 4-clock latency.
// A new colour configuration takes effect only on a falling nVSYNC edge, so one frame never mixes matrices.
module vconv_multi #(
    parameter int COLOR_W   = 8,
    parameter int COEFF_W   = 20,
    parameter int SYNC_W    = 4,
    parameter int VSYNC_BIT = 3
) (
    input  logic                        VCLK,
    input  logic                        RST,
    input  logic [1:0]                  mode_i,
    input  logic                        limited_range_i,
    input  logic [SYNC_W+3*COLOR_W-1:0] vdata_i,
    output logic [SYNC_W+3*COLOR_W-1:0] vdata_o,
    output logic [2:0]                  mode_o,
    output logic                        mode_update_o
);

    localparam int PIX_W  = 3 * COLOR_W;
    localparam int PROD_W = COLOR_W + COEFF_W;
    localparam int SUM_W  = PROD_W + 3;

    localparam logic signed [SUM_W-1:0] HALF  = SUM_W'(1) <<< (COEFF_W - 1);
    localparam logic signed [SUM_W-1:0] C_OFF = SUM_W'(1) <<< (COLOR_W - 1 + COEFF_W);
    localparam logic signed [SUM_W-1:0] Y_OFF = SUM_W'(16) <<< (COLOR_W - 8 + COEFF_W);

    function automatic logic [COEFF_W-1:0] fixq(input real v);
        return COEFF_W'($rtoi(v * real'(64'd1 << COEFF_W) + 0.5));
    endfunction

    // Coefficient magnitudes; the matrix signs are applied in the adders.
    // Order: Y(R,G,B), Pb(R,G,B), Pr(R,G,B).
    function automatic logic [8:0][COEFF_W-1:0] coef_set(input logic hd, input logic lim);
        logic [8:0][COEFF_W-1:0] c;
        real sy;
        real sc;
        sy = lim ? 219.0 / 255.0 : 1.0;
        sc = lim ? 224.0 / 255.0 : 1.0;
        c[0] = fixq((hd ? 0.2126   : 0.299)    * sy);
        c[1] = fixq((hd ? 0.7152   : 0.587)    * sy);
        c[2] = fixq((hd ? 0.0722   : 0.114)    * sy);
        c[3] = fixq((hd ? 0.114572 : 0.168736) * sc);
        c[4] = fixq((hd ? 0.385428 : 0.331264) * sc);
        c[5] = fixq(0.5 * sc);
        c[6] = fixq(0.5 * sc);
        c[7] = fixq((hd ? 0.454153 : 0.418688) * sc);
        c[8] = fixq((hd ? 0.045847 : 0.081312) * sc);
        return c;
    endfunction

    localparam logic [8:0][COEFF_W-1:0] C601F = coef_set(1'b0, 1'b0);
    localparam logic [8:0][COEFF_W-1:0] C601L = coef_set(1'b0, 1'b1);
    localparam logic [8:0][COEFF_W-1:0] C709F = coef_set(1'b1, 1'b0);
    localparam logic [8:0][COEFF_W-1:0] C709L = coef_set(1'b1, 1'b1);

    function automatic logic signed [SUM_W-1:0] ext(input logic [PROD_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic [COLOR_W-1:0] round_clamp(input logic signed [SUM_W-1:0] x);
        logic signed [SUM_W-1:0] r;
        r = (x + HALF) >>> COEFF_W;
        if (r[SUM_W-1]) return '0;
        if (|r[SUM_W-2:COLOR_W]) return '1;
        return r[COLOR_W-1:0];
    endfunction

    typedef enum logic {RUN, PENDING} state_t;

    state_t                   state, state_next;
    logic [2:0]               req, active_next;
    logic                     vs_fall, update;

    logic [SYNC_W-1:0]        sync_p0, sync_p1, sync_p2;
    logic [2:0][COLOR_W-1:0]  rgb_p0, rgb_p1, rgb_p2;
    logic [2:0]               cfg_p0, cfg_p1;
    logic [1:0]               mode_p2;
    logic [8:0][COEFF_W-1:0]  coef;
    logic [8:0][PROD_W-1:0]   prod_p1;
    logic signed [SUM_W-1:0]  y_p2, pb_p2, pr_p2;

    assign req     = {limited_range_i, (mode_i == 2'b11) ? 2'b00 : mode_i};
    assign vs_fall = sync_p0[VSYNC_BIT] & ~vdata_i[PIX_W+VSYNC_BIT];

    always_comb begin
        state_next = state;
        update     = 1'b0;
        case (state)
            RUN: begin
                if (req != mode_o) state_next = PENDING;
            end
            PENDING: begin
                if (req == mode_o) begin
                    state_next = RUN;
                end else if (vs_fall) begin
                    update     = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // The edge pixel enters s0 together with the freshly loaded config.
    assign active_next = update ? req : mode_o;

    always_ff @(posedge VCLK) begin
        if (RST) begin
            state         <= RUN;
            mode_o        <= '0;
            mode_update_o <= 1'b0;
        end else begin
            state         <= state_next;
            mode_o        <= active_next;
            mode_update_o <= update;
        end
    end

    always_comb begin
        coef = C601F;
        case ({cfg_p0[2], cfg_p0[1:0] == 2'b10})
            2'b01:   coef = C709F;
            2'b10:   coef = C601L;
            2'b11:   coef = C709L;
            default: coef = C601F;
        endcase
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            sync_p0 <= '0;
            rgb_p0  <= '0;
            cfg_p0  <= '0;
            sync_p1 <= '0;
            rgb_p1  <= '0;
            cfg_p1  <= '0;
            prod_p1 <= '0;
            sync_p2 <= '0;
            rgb_p2  <= '0;
            mode_p2 <= '0;
            y_p2    <= '0;
            pb_p2   <= '0;
            pr_p2   <= '0;
            vdata_o <= '0;
        end else begin
            // s0: input pixel and its config
            sync_p0 <= vdata_i[PIX_W+SYNC_W-1:PIX_W];
            rgb_p0  <= vdata_i[PIX_W-1:0];
            cfg_p0  <= active_next;
            // s1: nine unsigned products
            sync_p1 <= sync_p0;
            rgb_p1  <= rgb_p0;
            cfg_p1  <= cfg_p0;
            for (int o = 0; o < 3; o++) begin
                for (int c = 0; c < 3; c++) begin
                    prod_p1[3*o+c] <= PROD_W'(coef[3*o+c]) * PROD_W'(rgb_p0[2-c]);
                end
            end
            // s2: signed sums with offsets
            sync_p2 <= sync_p1;
            rgb_p2  <= rgb_p1;
            mode_p2 <= cfg_p1[1:0];
            y_p2    <= ext(prod_p1[0]) + ext(prod_p1[1]) + ext(prod_p1[2])
                       + (cfg_p1[2] ? Y_OFF : '0);
            pb_p2   <= C_OFF - ext(prod_p1[3]) - ext(prod_p1[4]) + ext(prod_p1[5]);
            pr_p2   <= C_OFF + ext(prod_p1[6]) - ext(prod_p1[7]) - ext(prod_p1[8]);
            // s3: round, clamp and select the output format
            if (mode_p2 == 2'b00) begin
                vdata_o <= {sync_p2, rgb_p2};
            end else begin
                vdata_o <= {sync_p2, round_clamp(pr_p2), round_clamp(y_p2), round_clamp(pb_p2)};
            end
        end
    end

endmodule

// File: tb/tb_vconv_multi.sv
// Bench for vconv_multi: directed sequence plus random pixels against a frame-level reference model.
module tb_vconv_multi;

    logic        VCLK = 1'b0;
    logic        RST;
    logic [1:0]  mode_i;
    logic        limited_range_i;
    logic [27:0] vdata_i;
    logic [27:0] vdata_o;
    logic [2:0]  mode_o;
    logic        mode_update_o;

    always #5 VCLK = ~VCLK;

    vconv_multi dut (
        .VCLK            (VCLK),
        .RST             (RST),
        .mode_i          (mode_i),
        .limited_range_i (limited_range_i),
        .vdata_i         (vdata_i),
        .vdata_o         (vdata_o),
        .mode_o          (mode_o),
        .mode_update_o   (mode_update_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    // Reference state: active config, last request, last nVSYNC, 4-deep output delay.
    logic [2:0]  act_m      = '0;
    logic [2:0]  prev_req_m = '0;
    logic        prev_vs_m  = 1'b0;
    logic        upd_m      = 1'b0;
    logic [27:0] pipe_m [4] = '{default: '0};

    function automatic longint cq(input real v);
        return longint'($rtoi(v * 1048576.0 + 0.5));
    endfunction

    function automatic logic [7:0] clamp8(input longint v);
        longint q;
        q = (v + 524288) >>> 20;
        if (q < 0) return 8'd0;
        if (q > 255) return 8'd255;
        return q[7:0];
    endfunction

    function automatic logic [27:0] convert(input logic [2:0] cfg, input logic [27:0] pix);
        longint r, g, b, y, pb, pr;
        real    sy, sc;
        logic   hd;
        if (cfg[1:0] == 2'b00) return pix;
        r  = longint'(pix[23:16]);
        g  = longint'(pix[15:8]);
        b  = longint'(pix[7:0]);
        hd = (cfg[1:0] == 2'b10);
        sy = cfg[2] ? 219.0 / 255.0 : 1.0;
        sc = cfg[2] ? 224.0 / 255.0 : 1.0;
        y  = cq((hd ? 0.2126 : 0.299) * sy) * r + cq((hd ? 0.7152 : 0.587) * sy) * g
           + cq((hd ? 0.0722 : 0.114) * sy) * b + (cfg[2] ? 64'sd16 : 64'sd0) * 1048576;
        pb = -cq((hd ? 0.114572 : 0.168736) * sc) * r - cq((hd ? 0.385428 : 0.331264) * sc) * g
           + cq(0.5 * sc) * b + 128 * 1048576;
        pr = cq(0.5 * sc) * r - cq((hd ? 0.454153 : 0.418688) * sc) * g
           - cq((hd ? 0.045847 : 0.081312) * sc) * b + 128 * 1048576;
        return {pix[27:24], clamp8(pr), clamp8(y), clamp8(pb)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // One pixel per call: drive at the falling edge, update the model, sample at the next falling edge.
    task automatic cycle(input logic [3:0] s, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [2:0] req;
        logic       vs;
        vdata_i = {s, r, g, b};
        req     = {limited_range_i, (mode_i == 2'b11) ? 2'b00 : mode_i};
        vs      = s[3];
        if (RST) begin
            act_m      = '0;
            prev_req_m = '0;
            prev_vs_m  = 1'b0;
            upd_m      = 1'b0;
            for (int i = 0; i < 4; i++) pipe_m[i] = '0;
        end else begin
            // A change takes effect at a falling edge only if it was already requested the cycle before.
            upd_m = prev_vs_m && !vs && (prev_req_m != act_m) && (req != act_m);
            if (upd_m) act_m = req;
            for (int i = 3; i > 0; i--) pipe_m[i] = pipe_m[i-1];
            pipe_m[0]  = convert(act_m, vdata_i);
            prev_req_m = req;
            prev_vs_m  = vs;
        end
        @(posedge VCLK);
        @(negedge VCLK);
        check("vdata", vdata_o, pipe_m[3]);
        check("mode_o", mode_o, act_m);
        check("mode_update", mode_update_o, upd_m);
        if (mode_update_o) pulses++;
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++)
            cycle({1'b1, 3'($urandom)}, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic vs_edge();
        cycle({1'b0, 3'($urandom)}, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic conv_check(input string tag, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic [23:0] exp);
        repeat (4) cycle(4'b1000, r, g, b);
        check(tag, vdata_o[23:0], exp);
    endtask

    initial begin
        RST             = 1'b1;
        mode_i          = 2'b00;
        limited_range_i = 1'b0;
        vdata_i         = '0;
        @(negedge VCLK);

        // Reset and latency in RGB
        repeat (3) cycle(4'hA, 8'd12, 8'd34, 8'd56);
        check("rst_vdata", vdata_o, 32'd0);
        check("rst_mode", mode_o, 32'd0);
        RST = 1'b0;
        cycle(4'hA, 8'd12, 8'd34, 8'd56);
        cycle(4'h8, 8'd0, 8'd0, 8'd0);
        cycle(4'h8, 8'd0, 8'd0, 8'd0);
        check("lat_early", vdata_o, 32'd0);
        cycle(4'h8, 8'd0, 8'd0, 8'd0);
        check("latency", vdata_o, {4'hA, 8'd12, 8'd34, 8'd56});
        rand_run(20);

        // Rec.601 full range
        mode_i = 2'b01;
        pulses = 0;
        rand_run(3);
        vs_edge();
        rand_run(2);
        check("pulse_601", pulses, 1);
        check("mode_601", mode_o, 3'b001);
        conv_check("601_white", 8'd255, 8'd255, 8'd255, {8'd128, 8'd255, 8'd128});
        conv_check("601_black", 8'd0, 8'd0, 8'd0, {8'd128, 8'd0, 8'd128});
        conv_check("601_red", 8'd255, 8'd0, 8'd0, {8'd255, 8'd76, 8'd85});
        rand_run(20);

        // Rec.709 full range
        mode_i = 2'b10;
        rand_run(2);
        vs_edge();
        rand_run(2);
        conv_check("709_red", 8'd255, 8'd0, 8'd0, {8'd255, 8'd54, 8'd99});
        conv_check("709_green", 8'd0, 8'd255, 8'd0, {8'd12, 8'd182, 8'd30});
        rand_run(20);

        // Rec.601 limited range
        mode_i          = 2'b01;
        limited_range_i = 1'b1;
        rand_run(2);
        vs_edge();
        rand_run(2);
        check("mode_601l", mode_o, 3'b101);
        conv_check("601l_white", 8'd255, 8'd255, 8'd255, {8'd128, 8'd235, 8'd128});
        conv_check("601l_black", 8'd0, 8'd0, 8'd0, {8'd128, 8'd16, 8'd128});
        rand_run(20);

        // Deferred switch RGB -> 601
        mode_i          = 2'b00;
        limited_range_i = 1'b0;
        rand_run(2);
        vs_edge();
        rand_run(2);
        pulses = 0;
        mode_i = 2'b01;
        rand_run(8);
        check("defer_hold", mode_o, 3'b000);
        check("defer_nopulse", pulses, 0);
        cycle(4'b0000, 8'd255, 8'd0, 8'd0);
        check("defer_pulse", mode_update_o, 1'b1);
        repeat (3) cycle(4'b1000, 8'd0, 8'd0, 8'd0);
        check("defer_edge_pix", vdata_o[23:0], {8'd255, 8'd76, 8'd85});
        rand_run(2);
        check("defer_once", pulses, 1);

        // Toggle 01 -> 00 -> 01 within a frame
        pulses = 0;
        mode_i = 2'b00;
        rand_run(3);
        mode_i = 2'b01;
        rand_run(3);
        vs_edge();
        rand_run(2);
        check("toggle_nopulse", pulses, 0);
        check("toggle_mode", mode_o, 3'b001);

        // Request change coinciding with the edge while idle
        mode_i = 2'b10;
        vs_edge();
        rand_run(3);
        check("simul_nopulse", pulses, 0);
        check("simul_mode", mode_o, 3'b001);
        vs_edge();
        rand_run(1);
        check("simul_next", pulses, 1);
        check("simul_mode2", mode_o, 3'b010);

        // Reset while a change is pending
        mode_i = 2'b01;
        rand_run(3);
        pulses = 0;
        RST    = 1'b1;
        rand_run(2);
        RST = 1'b0;
        rand_run(3);
        check("rstp_nopulse", pulses, 0);
        check("rstp_mode", mode_o, 3'b000);
        vs_edge();
        rand_run(1);
        check("rstp_redetect", pulses, 1);
        check("rstp_mode2", mode_o, 3'b001);

        // Reserved mode with limited flag: passthrough, flag stored
        mode_i          = 2'b11;
        limited_range_i = 1'b1;
        rand_run(2);
        vs_edge();
        rand_run(3);
        check("rsv_mode", mode_o, 3'b100);
        conv_check("rsv_pass", 8'd12, 8'd34, 8'd56, {8'd12, 8'd34, 8'd56});

        // Random frames with occasional config changes and one reset
        for (int i = 0; i < 400; i++) begin
            logic vs;
            if ($urandom_range(0, 29) == 0) begin
                mode_i          = 2'($urandom);
                limited_range_i = 1'($urandom);
            end
            RST = (i >= 200 && i < 202);
            vs  = ((i % 40) >= 3);
            cycle({vs, 3'($urandom)}, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        RST = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
